load_store_unit: RTL

Multi-cycle load/store unit sitting directly downstream of the ALU: it takes the ALU result as the effective address and rs2 as store data, and runs a req/ack transaction on the data-memory bus. It also generates byte enables, replicates store lanes, and sign- or zero-extends load data. While a transaction is outstanding it stalls the core, then returns one completion pulse with load data or an error.

---
 rtl/load_store_unit.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: runs one req/ack data-memory transaction per instruction, with lane steering and load extension.
// Optional LSU_MISALIGN_TRAP_EN makes misaligned accesses fail without a bus access (default: low address bits are cleared).
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_stall_o,
  output logic        lsu_done_o,
  output logic        lsu_err_o,
  output logic [31:0] lsu_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [1:0]       off_q, off_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;

  logic        legal;
  logic        misaligned;
  logic [31:0] addr_fix;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;

  // Decode of the incoming instruction, using the address with its offending low bits cleared.
  always_comb begin
    if (lsu_we_i) legal = (lsu_funct3_i == 3'b000) || (lsu_funct3_i == 3'b001) || (lsu_funct3_i == 3'b010);
    else          legal = (lsu_funct3_i[1:0] != 2'b11) && (lsu_funct3_i != 3'b110);
    misaligned = ((lsu_funct3_i[1:0] == 2'b01) && lsu_addr_i[0]) ||
                 ((lsu_funct3_i[1:0] == 2'b10) && (lsu_addr_i[1:0] != 2'b00));
    addr_fix = lsu_addr_i;
    if (lsu_funct3_i[1:0] == 2'b01) addr_fix[0] = 1'b0;
    if (lsu_funct3_i[1:0] == 2'b10) addr_fix[1:0] = 2'b00;
    case (lsu_funct3_i[1:0])
      2'b00: begin
        be_new    = 4'b0001 << addr_fix[1:0];
        wdata_new = {4{lsu_wdata_i[7:0]}};
      end
      2'b01: begin
        be_new    = addr_fix[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{lsu_wdata_i[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = lsu_wdata_i;
      end
    endcase
    if (!lsu_we_i) wdata_new = 32'h0;
  end

  always_comb begin
    byte_lane = mem_rdata_i[{off_q, 3'b000} +: 8];
    half_lane = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_ext = {24'h0, byte_lane};
      3'b101:  load_ext = {16'h0, half_lane};
      default: load_ext = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (lsu_valid_i) begin
          if (!legal || (TRAP_EN && misaligned)) begin
            state_d = RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d  = REQ;
            cnt_d    = '0;
            req_d    = 1'b1;
            we_d     = lsu_we_i;
            addr_d   = {addr_fix[31:2], 2'b00};
            be_d     = be_new;
            wdata_d  = wdata_new;
            funct3_d = lsu_funct3_i;
            off_d    = addr_fix[1:0];
          end
        end
      end
      REQ: begin
        if (mem_ack_i || (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          state_d = RESP;
          done_d  = 1'b1;
          err_d   = !mem_ack_i;
          rdata_d = (mem_ack_i && !we_q) ? load_ext : 32'h0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = 32'h0;
          be_d    = 4'h0;
          wdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign lsu_stall_o = (state_q == REQ) || ((state_q == IDLE) && lsu_valid_i);
  assign lsu_done_o  = done_q;
  assign lsu_err_o   = err_q;
  assign lsu_rdata_o = rdata_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;

endmodule
